// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and constants for the Gray-code conversion arbiter.
// Optional feature macro: GRAY_CONV_DECODE_EN (adds Gray-to-binary decode).
package gray_conv_pkg;

  localparam int GRAY_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Requester/result bus shared by the arbiter and its environment.
// Optional feature macro: GRAY_CONV_DECODE_EN (adds per-requester req_mode).
interface gray_conv_arbiter_if #(
  parameter int WIDTH = gray_conv_pkg::GRAY_WIDTH_DEF
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;
`ifdef GRAY_CONV_DECODE_EN
  logic [1:0]       req_mode;

  modport master (
    output req_valid, req_data0, req_data1, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
`else
  modport master (
    output req_valid, req_data0, req_data1, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/gray_conv_arbiter_xcode.sv
// Purely combinational binary<->Gray converter, shared by both requesters.
// Optional feature macro: GRAY_CONV_DECODE_EN (i_mode=1 selects decode).
module gray_xcode #(
  parameter int WIDTH = gray_conv_pkg::GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_data,
`ifdef GRAY_CONV_DECODE_EN
  input  logic             i_mode,
`endif
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_enc;

  assign w_enc = i_data ^ (i_data >> 1);

`ifdef GRAY_CONV_DECODE_EN
  logic [WIDTH-1:0] w_dec;

  // Decode is a running XOR from the MSB down.
  always_comb begin
    w_dec            = '0;
    w_dec[WIDTH-1]   = i_data[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      w_dec[k] = w_dec[k+1] ^ i_data[k];
    end
  end

  assign o_data = i_mode ? w_dec : w_enc;
`else
  assign o_data = w_enc;
`endif

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a one-deep Gray conversion
// result register. Optional feature macro: GRAY_CONV_DECODE_EN.
//
// state | meaning
// IDLE  | result register empty, out_valid=0
// HOLD  | result register holds a word, out_valid=1
module gray_conv_arbiter #(
  parameter int WIDTH = gray_conv_pkg::GRAY_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  gray_conv_arbiter_if.slave bus
);
  import gray_conv_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  req_idx_t         r_last;
  req_idx_t         w_grant;
  logic             w_can_accept;
  logic             w_accept;
  logic [1:0]       w_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_xcode;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_id;

  // Round-robin pick: a lone requester wins, contention goes to the one not granted last.
  always_comb begin
    w_grant = 1'b0;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_can_accept = (r_state == IDLE) || bus.out_ready;

  // rst_n gates ready so nothing is offered while reset is asserted.
  assign w_ready  = (rst_n && w_can_accept && (|bus.req_valid)) ?
                    (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_accept = |(bus.req_valid & w_ready);

  assign w_sel_data = w_grant ? bus.req_data1 : bus.req_data0;

  gray_xcode #(.WIDTH(WIDTH)) u_xcode (
    .i_data (w_sel_data),
`ifdef GRAY_CONV_DECODE_EN
    .i_mode (bus.req_mode[w_grant]),
`endif
    .o_data (w_xcode)
  );

  // Next-state logic for the result register occupancy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = HOLD;
      HOLD:    if (bus.out_ready && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result register and grant pointer advance only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_id   <= 1'b0;
      r_last     <= 1'b1;
    end else if (w_accept) begin
      r_out_data <= w_xcode;
      r_out_id   <= w_grant;
      r_last     <= w_grant;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter.
// Optional feature macro: GRAY_CONV_DECODE_EN (enables the decode scenario).
module tb_gray_conv_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gray_conv_arbiter_if #(.WIDTH(8)) bus ();

  gray_conv_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data0 = 8'h0F;
    bus.req_data1 = 8'hF0;
    bus.out_ready = 1'b1;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data);
    end
    checks++;
    if (bus.out_id !== 1'b0) begin
      failures++; $display("FAIL reset_out_id got=%b exp=0", bus.out_id);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_held_out_valid got=%b exp=0", bus.out_valid);
    end
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    #1;
  endtask

  task automatic test_contention();
    logic [7:0] exp_data;
    logic       exp_id;
    bus.req_valid = 2'b11;
    bus.req_data0 = 8'h0F;
    bus.req_data1 = 8'hF0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id   = (i % 2 == 1);
      exp_data = exp_id ? 8'h88 : 8'h08;
      #1;
      checks++;
      if (bus.req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL contention_ready[%0d] got=%b exp=%b", i, bus.req_ready, exp_id ? 2'b10 : 2'b01);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data || bus.out_id !== exp_id) begin
        failures++;
        $display("FAIL contention_out[%0d] got=%b/%h/%b exp=1/%h/%b", i, bus.out_valid, bus.out_data, bus.out_id, exp_data, exp_id);
      end
    end
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL contention_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_single();
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'hBB;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL single_ready got=%b exp=01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE6 || bus.out_id !== 1'b0) begin
      failures++; $display("FAIL single_out got=%b/%h/%b exp=1/e6/0", bus.out_valid, bus.out_data, bus.out_id);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int transfers;
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'hBB;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data1 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE6 || bus.out_id !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/e6/0", i, bus.out_valid, bus.out_data, bus.out_id);
      end
    end
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b1;
    transfers     = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) transfers++;
      tick();
    end
    checks++;
    if (transfers !== 1) begin
      failures++; $display("FAIL bp_release_transfers got=%0d exp=1", transfers);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] vin  [3];
    logic [7:0] vexp [3];
    vin[0] = 8'h00; vexp[0] = 8'h00;
    vin[1] = 8'hFF; vexp[1] = 8'h80;
    vin[2] = 8'h80; vexp[2] = 8'hC0;
    bus.req_valid = 2'b10;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_data1 = vin[i];
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
        failures++; $display("FAIL bound_ready[%0d] got=%b exp=10", i, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vexp[i] || bus.out_id !== 1'b1) begin
        failures++; $display("FAIL bound_out[%0d] got=%b/%h/%b exp=1/%h/1", i, bus.out_valid, bus.out_data, bus.out_id, vexp[i]);
      end
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 2'b01;
    bus.req_data0 = 8'hBB;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 2'b00 || bus.out_data !== 8'h00) begin
      failures++; $display("FAIL midrst_async got=%b/%b/%h exp=0/00/00", bus.out_valid, bus.req_ready, bus.out_data);
    end
    tick();
    rst_n         = 1'b1;
    bus.req_data0 = 8'h0F;
    bus.req_data1 = 8'hF0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL midrst_first_ready got=%b exp=01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08 || bus.out_id !== 1'b0) begin
      failures++; $display("FAIL midrst_first_out got=%b/%h/%b exp=1/08/0", bus.out_valid, bus.out_data, bus.out_id);
    end
    tick();
  endtask

`ifdef GRAY_CONV_DECODE_EN
  task automatic test_decode();
    bus.req_mode  = 2'b10;
    bus.req_valid = 2'b10;
    bus.req_data1 = 8'hE6;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 2'b00;
    bus.req_mode  = 2'b00;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hBB || bus.out_id !== 1'b1) begin
      failures++; $display("FAIL decode_out got=%b/%h/%b exp=1/bb/1", bus.out_valid, bus.out_data, bus.out_id);
    end
    tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
`ifdef GRAY_CONV_DECODE_EN
    bus.req_mode = 2'b00;
`endif
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
`ifdef GRAY_CONV_DECODE_EN
    test_decode();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
